// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-expansion engine (aes_keyexp) and its
// S-box sub-module (aes_subword).
//   - key_size encodings (KS128, KS192; any 1x value selects 256-bit)
//   - FSM state enum
//   - per-key-size configuration lookup (Nk, Nr and total schedule words)
//   - GF(2^8) xtime and the forward AES S-box
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int MAXW  = 60;   // key-store depth in 32-bit words
    localparam int NSLOT = 15;   // 128-bit round-key slots presented

    localparam logic [1:0] KS128 = 2'b00;
    localparam logic [1:0] KS192 = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    // Total schedule words is 4*(Nr+1); the engine needs Nk and the total.
    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
        logic [5:0] total;
    } ks_cfg_t;

    function automatic ks_cfg_t ks_lookup(input logic [1:0] key_size);
        ks_cfg_t cfg;
        case (key_size)
            KS128:   cfg = '{nk: 4'd4, nr: 4'd10, total: 6'd44};
            KS192:   cfg = '{nk: 4'd6, nr: 4'd12, total: 6'd52};
            default: cfg = '{nk: 4'd8, nr: 4'd14, total: 6'd60};
        endcase
        return cfg;
    endfunction

    // Multiply by x in GF(2^8), reduced by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

endpackage

// File: rtl/aes_keyexp_if.sv
// ---------------------------------------------------------------------------
// aes_keyexp_if
// Request/result bundle of the key-expansion engine.
//   start      master->slave  single-cycle pulse, sample key/key_size
//   key        master->slave  256-bit cipher key, MSB-justified
//   key_size   master->slave  00=128, 01=192, 1x=256
//   key_words  slave->master  round keys, slot 15 = round key 0
//   ready      slave->master  schedule complete (level)
//   busy       slave->master  expansion in progress
// ---------------------------------------------------------------------------
interface aes_keyexp_if;

    logic                                 start;
    logic [255:0]                         key;
    logic [1:0]                           key_size;
    logic [aes_pkg::NSLOT:1][127:0]       key_words;
    logic                                 ready;
    logic                                 busy;

    modport master (
        output start, key, key_size,
        input  key_words, ready, busy
    );

    modport slave (
        input  start, key, key_size,
        output key_words, ready, busy
    );

endinterface

// File: rtl/aes_subword.sv
// ---------------------------------------------------------------------------
// aes_subword
// Purely combinational AES SubWord: four parallel S-box lookups.
//   din   in  32  input word
//   dout  out 32  byte-wise S-box substitution of din
// ---------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {sbox(din[31:24]), sbox(din[23:16]),
                   sbox(din[15:8]),  sbox(din[7:0])};

endmodule

// File: rtl/aes_keyexp.sv
// ---------------------------------------------------------------------------
// aes_keyexp
// Iterative AES key expansion: loads a 128/192/256-bit key on start and then
// produces one 32-bit schedule word per clock until the full schedule for the
// selected key size is in the store. The store is presented as 15 round-key
// slots (slot 15 = round key 0).
//   eph1    in   clock, all state on the rising edge
//   reset   in   asynchronous active-low reset
//   bus     slave modport of aes_keyexp_if (start/key/key_size in,
//                key_words/ready/busy out)
// Build option: define AES_KEYEXP_ZEROIZE_EN to clear every store word above
// the loaded key on each start, so no previous key material persists.
// ---------------------------------------------------------------------------
module aes_keyexp
    import aes_pkg::*;
(
    input  logic        eph1,
    input  logic        reset,
    aes_keyexp_if.slave bus
);

    state_t      state;
    logic [31:0] w [MAXW];
    logic [5:0]  i;          // next word index to write
    logic [2:0]  j;          // i mod Nk
    logic [7:0]  rcon;
    ks_cfg_t     cfg;        // configuration latched at start
    logic        ready_q;
    logic        busy_q;

    ks_cfg_t     start_cfg;
    logic [31:0] key_w [8];
    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;
    logic        j_first;
    logic        j_mid;
    logic [NSLOT:1][127:0] slots;

    assign start_cfg = ks_lookup(bus.key_size);

    for (genvar k = 0; k < 8; k++) begin : g_key
        assign key_w[k] = bus.key[255-32*k -: 32];
    end

    // Next-word datapath: w[i] = w[i-Nk] ^ f(w[i-1]).
    assign prev    = w[i - 6'd1];
    assign back    = w[i - {2'b00, cfg.nk}];
    assign j_first = (j == 3'd0);
    assign j_mid   = (cfg.nk == 4'd8) && (j == 3'd4);
    assign sub_in  = j_first ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        // NOTE: temp gets a default before any branch so no latch is inferred.
        temp = prev;
        if (j_first) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (j_mid) begin
            temp = sub_out;
        end
    end

    assign new_word = back ^ temp;

    // NOTE: all state here uses <= so every register sees pre-edge values.
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            rcon    <= 8'h01;
            cfg     <= ks_lookup(KS128);
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            // NOTE: the key store is cleared on reset so key_words reads zero
            // and no key material survives a reset.
            for (int k = 0; k < MAXW; k++) begin
                w[k] <= '0;
            end
        end else if (bus.start) begin
            // A start in any state (including the last-word edge) wins.
            state   <= EXPAND;
            cfg     <= start_cfg;
            i       <= {2'b00, start_cfg.nk};
            j       <= '0;
            rcon    <= 8'h01;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k < int'(start_cfg.nk)) begin
                    w[k] <= key_w[k];
                end
            end
`ifdef AES_KEYEXP_ZEROIZE_EN
            for (int k = 0; k < MAXW; k++) begin
                if (k >= int'(start_cfg.nk)) begin
                    w[k] <= '0;
                end
            end
`endif
        end else begin
            case (state)
                EXPAND: begin
                    w[i] <= new_word;
                    i    <= i + 6'd1;
                    j    <= ({1'b0, j} == cfg.nk - 4'd1) ? 3'd0 : j + 3'd1;
                    if (j_first) begin
                        rcon <= xtime(rcon);
                    end
                    if (i == cfg.total - 6'd1) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot s holds words 4*(15-s) .. 4*(15-s)+3, first word in the top bits.
    always_comb begin
        for (int s = 1; s <= NSLOT; s++) begin
            slots[s] = {w[4*(NSLOT-s)],     w[4*(NSLOT-s) + 1],
                        w[4*(NSLOT-s) + 2], w[4*(NSLOT-s) + 3]};
        end
    end

    assign bus.key_words = slots;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_keyexp.sv
// ---------------------------------------------------------------------------
// tb_aes_keyexp
// Self-checking bench for aes_keyexp. A driver issues key-expansion requests
// (FIPS-197 vectors plus random keys, aborts, same-edge restarts and resets)
// and pushes the expected schedule and ready cycle into a scoreboard queue; a
// monitor pops and compares whenever ready rises. The reference model builds
// the S-box from GF(2^8) inversion and expands keys with the FIPS-197
// algorithm, tracking which store words each (possibly aborted) run rewrote.
// ---------------------------------------------------------------------------
module tb_aes_keyexp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aes_keyexp_if bus ();

    aes_keyexp dut (
        .eph1  (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ model
    logic [7:0]  sbox_m    [256];
    logic [31:0] m_store   [60];
    logic [31:0] cur_sched [60];
    bit          cur_active;
    int          cur_s;
    int          cur_nk;
    int          cur_total;

    typedef struct {
        logic [15:1][127:0] kw;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(a));   // a^254 = a^-1
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    function automatic int nk_of(input logic [1:0] ks);
        return (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
    endfunction

    task automatic build_sched(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        int          total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        for (int k = 0; k < nk; k++) cur_sched[k] = key[255-32*k -: 32];
        for (int k = nk; k < total; k++) begin
            t = cur_sched[k-1];
            if (k % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && k % nk == 4) begin
                t = sub_w(t);
            end
            cur_sched[k] = cur_sched[k-nk] ^ t;
        end
    endtask

    // Called at a falling edge; the start edge is the next rising edge.
    task automatic start_run(input logic [255:0] key, input logic [1:0] ks);
        exp_t         e;
        int           p, n, nk, total, idx;
        logic [127:0] slot;
        p = cyc + 1;
        if (cur_active) begin
            // An interrupted run has written one word per cycle since its start.
            n = p - 1 - cur_s;
            if (n > cur_total - cur_nk) n = cur_total - cur_nk;
            for (int k = cur_nk; k < cur_nk + n; k++) m_store[k] = cur_sched[k];
        end
        nk    = nk_of(ks);
        total = 4 * (nk + 7);
        for (int k = 0; k < 60; k++) begin
            if (k < nk) m_store[k] = key[255-32*k -: 32];
`ifdef AES_KEYEXP_ZEROIZE_EN
            else m_store[k] = 32'h0;
`endif
        end
        build_sched(key, nk);
        for (int s = 1; s <= 15; s++) begin
            for (int b = 0; b < 4; b++) begin
                idx = 4 * (15 - s) + b;
                slot[127-32*b -: 32] = (idx < total) ? cur_sched[idx] : m_store[idx];
            end
            e.kw[s] = slot;
        end
        e.cyc = p + total - nk;
        sb.delete();
        sb.push_back(e);
        cur_active = 1'b1;
        cur_s      = p;
        cur_nk     = nk;
        cur_total  = total;
        bus.start    = 1'b1;
        bus.key      = key;
        bus.key_size = ks;
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble inputs: the engine must only use the values latched at start.
        for (int k = 0; k < 8; k++) bus.key[32*k +: 32] = $urandom;
        bus.key_size = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ready not seen within %0d cycles", name, n);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int s = 1; s <= 15; s++)
            check($sformatf("%s_slot%0d", tag, s), bus.key_words[s], 128'h0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 60; k++) m_store[k] = 32'h0;
        cur_active = 1'b0;
        sb.delete();
    endtask

    // ------------------------------------------------------------ monitor
    bit rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.ready && !rdy_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ready_cycle", 128'(cyc), 128'(mon_e.cyc));
                check("done_busy", 128'(bus.busy), 128'h0);
                for (int s = 1; s <= 15; s++)
                    check($sformatf("slot%0d", s), bus.key_words[s], mon_e.kw[s]);
            end
        end
        rdy_prev = bus.ready;
    end

    // ------------------------------------------------------------ stimulus
    localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        logic [255:0] rk;
        logic [1:0]   rks;
        int           s0, lat, wait_n;

        bus.start    = 1'b0;
        bus.key      = '0;
        bus.key_size = 2'b00;
        build_sbox();
        model_reset();

        // Reset state.
        @(negedge clk);
        check("rst_ready", 128'(bus.ready), 128'h0);
        check("rst_busy",  128'(bus.busy),  128'h0);
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 / A.2 / A.3.
        start_run(KEY_A1, 2'b00);
        check("a1_busy", 128'(bus.busy), 128'h1);
        wait_done("a1");
        check("a1_rk1_w4", 128'(bus.key_words[14][127:96]), 128'ha0fafe17);
        check("a1_rk10", bus.key_words[5], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        start_run(KEY_A2, 2'b01);
        wait_done("a2");
        check("a2_rk12", bus.key_words[3], 128'he98ba06f448c773c8ecc720401002202);

        start_run(KEY_A3, 2'b10);
        wait_done("a3");
        check("a3_rk14", bus.key_words[1], 128'hfe4890d1e6188d0b046df344706c631e);
        repeat (3) @(negedge clk);
        check("ready_held", 128'(bus.ready), 128'h1);

        // Abort an A.1 run 20 cycles in and restart it.
        start_run(KEY_A1, 2'b00);
        repeat (19) @(negedge clk);
        start_run(KEY_A1, 2'b00);
        wait_done("a1_restart");
        check("restart_rk10", bus.key_words[5], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEYEXP_ZEROIZE_EN
        check("restart_slot1", bus.key_words[1], 128'h0);
`else
        check("restart_slot1", bus.key_words[1], 128'hfe4890d1e6188d0b046df344706c631e);
`endif

        // Reset 25 cycles into an A.3 run.
        start_run(KEY_A3, 2'b10);
        s0 = cur_s;
        while (cyc < s0 + 25) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_ready", 128'(bus.ready), 128'h0);
        check("midrst_busy",  128'(bus.busy),  128'h0);
        check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(KEY_A3, 2'b10);
        wait_done("a3_after_rst");
        check("a3_after_rst_rk14", bus.key_words[1], 128'hfe4890d1e6188d0b046df344706c631e);

        // Start on the same edge as the final word of an A.1 run.
        start_run(KEY_A1, 2'b00);
        s0 = cur_s;
        while (cyc < s0 + 39) @(negedge clk);
        start_run(KEY_A1, 2'b00);
        check("collide_ready", 128'(bus.ready), 128'h0);
        check("collide_busy",  128'(bus.busy),  128'h1);
        wait_done("a1_collide");

        // Random keys and sizes, with occasional aborts.
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 8; k++) rk[32*k +: 32] = $urandom;
            rks = 2'($urandom_range(0, 3));
            start_run(rk, rks);
            if ($urandom_range(0, 9) < 3) begin
                lat    = 3 * nk_of(rks) + 28;
                wait_n = $urandom_range(1, lat - 1);
                repeat (wait_n) @(negedge clk);
                for (int k = 0; k < 8; k++) rk[32*k +: 32] = $urandom;
                rks = 2'($urandom_range(0, 3));
                start_run(rk, rks);
            end
            wait_done($sformatf("rand%0d", t));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
